// File: rtl/pacman_pkg.sv
// Shared types and constants for the Pac-Man motion controller.
package pacman_pkg;

  // Heading order matches adjacent_walls_vga: up, right, down, left.
  typedef enum logic [1:0] {
    UP    = 2'd0,
    RIGHT = 2'd1,
    DOWN  = 2'd2,
    LEFT  = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StTurn = 2'd1,
    StFwd  = 2'd2,
    StMove = 2'd3
  } state_t;

  localparam int unsigned TILE_SIZE  = 16;
  localparam int unsigned GRID_W     = 40;
  localparam int unsigned GRID_H     = 30;
  localparam logic [9:0]  X_WRAP_MAX = 10'd624;

  localparam logic [5:0] LAST_COL = 6'(GRID_W - 1);
  localparam logic [4:0] LAST_ROW = 5'(GRID_H - 1);

  localparam logic [7:0] KEY_W = 8'h1A;
  localparam logic [7:0] KEY_A = 8'h04;
  localparam logic [7:0] KEY_S = 8'h16;
  localparam logic [7:0] KEY_D = 8'h07;

  // Flipping bit 1 maps up<->down and right<->left.
  function automatic dir_t opposite(dir_t d);
    return dir_t'(d ^ 2'b10);
  endfunction

endpackage

// File: rtl/tile_neighbor.sv
// Combinational neighbour-tile lookup with horizontal tunnel wrap.
module tile_neighbor
  import pacman_pkg::*;
(
  input  logic [5:0] tile_x,
  input  logic [4:0] tile_y,
  input  logic [1:0] d,
  output logic [5:0] nbr_x,
  output logic [4:0] nbr_y,
  output logic       off_grid
);

  // Step one tile in d; rows above 0 or below the last row are off the grid.
  always_comb begin
    nbr_x    = tile_x;
    nbr_y    = tile_y;
    off_grid = 1'b0;
    case (dir_t'(d))
      UP: begin
        if (tile_y == 5'd0) off_grid = 1'b1;
        else                nbr_y    = tile_y - 5'd1;
      end
      DOWN: begin
        if (tile_y == LAST_ROW) off_grid = 1'b1;
        else                    nbr_y    = tile_y + 5'd1;
      end
      RIGHT: nbr_x = (tile_x == LAST_COL) ? 6'd0 : tile_x + 6'd1;
      LEFT:  nbr_x = (tile_x == 6'd0) ? LAST_COL : tile_x - 6'd1;
      default: ;
    endcase
  end

endmodule

// File: rtl/pacman_motion.sv
// Per-frame Pac-Man position controller: turn, wall check, one-pixel step.
module pacman_motion
  import pacman_pkg::*;
#(
  parameter logic [9:0] START_X = 10'd304,
  parameter logic [9:0] START_Y = 10'd368
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic [7:0] keycode,
  output logic [5:0] query_tile_x,
  output logic [4:0] query_tile_y,
  input  logic       query_is_wall,
  output logic [9:0] pacman_x,
  output logic [9:0] pacman_y,
  output logic [1:0] dir,
  output logic       moving,
  output logic       eat_valid,
  output logic [5:0] eat_tile_x,
  output logic [4:0] eat_tile_y
);

  state_t     state_q, state_d;
  logic [9:0] x_q, x_d, y_q, y_d;
  dir_t       dir_q, dir_d, req_dir_q, req_dir_d, query_dir;
  logic       req_valid_q, req_valid_d;
  logic       blocked_q, blocked_d;
  logic       moving_q, moving_d;
  logic       eat_valid_q, eat_valid_d;
  logic [5:0] eat_tx_q, eat_tx_d;
  logic [4:0] eat_ty_q, eat_ty_d;
  logic       frame_q;
  logic       frame_rise, aligned, off_grid, nbr_wall;

  assign frame_rise = frame_clk & ~frame_q;
  assign aligned    = (x_q[3:0] == 4'd0) && (y_q[3:0] == 4'd0);

  // TURN probes the requested heading; every other state probes the current one.
  assign query_dir = (state_q == StTurn) ? req_dir_q : dir_q;

  tile_neighbor u_tile_neighbor (
    .tile_x   (x_q[9:4]),
    .tile_y   (y_q[8:4]),
    .d        (query_dir),
    .nbr_x    (query_tile_x),
    .nbr_y    (query_tile_y),
    .off_grid (off_grid)
  );

  // Off-grid rows count as walls without trusting the ROM.
  assign nbr_wall = off_grid | query_is_wall;

  // Next-state and datapath updates for the four-step frame sequence.
  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    dir_d       = dir_q;
    req_dir_d   = req_dir_q;
    req_valid_d = req_valid_q;
    blocked_d   = blocked_q;
    moving_d    = moving_q;
    eat_valid_d = 1'b0;
    eat_tx_d    = eat_tx_q;
    eat_ty_d    = eat_ty_q;
    unique case (state_q)
      StIdle: if (frame_rise) state_d = StTurn;
      StTurn: begin
        state_d = StFwd;
        if (aligned && req_valid_q && (req_dir_q != dir_q)) begin
          if (!nbr_wall) dir_d = req_dir_q;
          req_valid_d = 1'b0;
        end else if (!aligned && req_valid_q && (req_dir_q == opposite(dir_q))) begin
          dir_d       = req_dir_q;
          req_valid_d = 1'b0;
        end
      end
      StFwd: begin
        state_d   = StMove;
        blocked_d = aligned & nbr_wall;
      end
      StMove: begin
        state_d  = StIdle;
        moving_d = ~blocked_q;
        if (!blocked_q) begin
          case (dir_q)
            UP:    y_d = y_q - 10'd1;
            DOWN:  y_d = y_q + 10'd1;
            RIGHT: x_d = (x_q == X_WRAP_MAX) ? 10'd0 : x_q + 10'd1;
            LEFT:  x_d = (x_q == 10'd0) ? X_WRAP_MAX : x_q - 10'd1;
            default: ;
          endcase
          if ((x_d[3:0] == 4'd0) && (y_d[3:0] == 4'd0)) begin
            eat_valid_d = 1'b1;
            eat_tx_d    = x_d[9:4];
            eat_ty_d    = y_d[8:4];
          end
        end
      end
      default: state_d = StIdle;
    endcase
    // A new key overrides the clear issued by TURN in the same cycle.
    case (keycode)
      KEY_W: begin req_dir_d = UP;    req_valid_d = 1'b1; end
      KEY_D: begin req_dir_d = RIGHT; req_valid_d = 1'b1; end
      KEY_S: begin req_dir_d = DOWN;  req_valid_d = 1'b1; end
      KEY_A: begin req_dir_d = LEFT;  req_valid_d = 1'b1; end
      default: ;
    endcase
  end

  // State register with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= StIdle;
      x_q         <= START_X;
      y_q         <= START_Y;
      dir_q       <= LEFT;
      req_dir_q   <= LEFT;
      req_valid_q <= 1'b0;
      blocked_q   <= 1'b0;
      moving_q    <= 1'b0;
      eat_valid_q <= 1'b0;
      eat_tx_q    <= 6'd0;
      eat_ty_q    <= 5'd0;
      frame_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      dir_q       <= dir_d;
      req_dir_q   <= req_dir_d;
      req_valid_q <= req_valid_d;
      blocked_q   <= blocked_d;
      moving_q    <= moving_d;
      eat_valid_q <= eat_valid_d;
      eat_tx_q    <= eat_tx_d;
      eat_ty_q    <= eat_ty_d;
      frame_q     <= frame_clk;
    end
  end

  assign pacman_x   = x_q;
  assign pacman_y   = y_q;
  assign dir        = dir_q;
  assign moving     = moving_q;
  assign eat_valid  = eat_valid_q;
  assign eat_tile_x = eat_tx_q;
  assign eat_tile_y = eat_ty_q;

endmodule

// File: doc/pacman_motion.md
# pacman_motion

Per-frame Pac-Man position controller that produces the `pacman_x`/`pacman_y` sprite coordinates consumed by `color_mapper`. Once per video frame it:
- takes the latest direction key,
- checks the maze wall map through a single-cycle tile query port,
- advances Pac-Man one pixel,
- reports tile-aligned arrival so the pellet store can clear the eaten pellet.

Pac-Man is a 16×16 tile; position is the tile's top-left pixel on a 40×30-tile, 640×480 grid.

## Interface

Parameters:
- `START_X`, 10'd304: reset x pixel; must be a multiple of 16.
- `START_Y`, 10'd368: reset y pixel; must be a multiple of 16.

Ports:
- `Clk`, in, 1: system clock.
- `Reset`, in, 1: synchronous, active-high.
- `frame_clk`, in, 1: VGA vsync level, synchronous to `Clk`; a rising edge starts one frame update.
- `keycode`, in, 8: USB HID keycode, 0 = no key.
- `query_tile_x`, out, 6: tile column being checked.
- `query_tile_y`, out, 5: tile row being checked.
- `query_is_wall`, in, 1: wall flag for the queried tile, combinational from the maze ROM, valid in the same cycle.
- `pacman_x`, `pacman_y`, out, 10: sprite top-left pixel.
- `dir`, out, 2: current heading. 0 up, 1 right, 2 down, 3 left (same order as `adjacent_walls_vga`).
- `moving`, out, 1: Pac-Man advanced on the last frame.
- `eat_valid`, out, 1: one-cycle pulse on arrival at a tile-aligned position.
- `eat_tile_x`, out, 6; `eat_tile_y`, out, 5: tile reached; valid while `eat_valid` is high.

## Operation

Direction request:
- `keycode` values 0x1A (W), 0x07 (D), 0x16 (S), 0x04 (A) load `req_dir` and set `req_valid`. This happens in any cycle, not only at frame updates.
- Other keycodes leave `req_dir`/`req_valid` unchanged.

Alignment: aligned = `pacman_x[3:0]==0 && pacman_y[3:0]==0`.

Neighbour tile of the current tile in direction d:
- x wraps 0↔39 (tunnel).
- y does not wrap. Row −1 or row 30 is treated as a wall without querying.

State machine:
- IDLE: wait for `frame_clk` rising edge (`frame_clk & ~frame_clk_q`), then go to TURN.
- TURN:
  - If aligned, `req_valid`, and `req_dir != dir`: drive the `req_dir` neighbour on the query port. If `query_is_wall`=0, `dir`←`req_dir`. `req_valid` clears either way.
  - If not aligned and `req_dir` is the opposite of `dir`: `dir`←`req_dir` with no query, and `req_valid` clears.
  - Otherwise nothing changes.
  - Always go to FWD.
- FWD:
  - If aligned, query the neighbour in `dir` (the value after TURN) and set `blocked`=`query_is_wall`.
  - If not aligned, `blocked`=0.
  - Go to MOVE.
- MOVE:
  - If `!blocked`, step one pixel in `dir` and set `moving`=1. Otherwise set `moving`=0.
  - x wrap: left from 0 → 624; right from 624 → 0.
  - If the new position is aligned and a step occurred: pulse `eat_valid` and load the `eat_tile_*` values.
  - Go to IDLE.
- `frame_clk` edges arriving outside IDLE are ignored. `frame_clk_q` still updates every cycle.
- Query port outputs are don't-care in IDLE and MOVE.

## Timing

- Reset values:
  - `pacman_x`=`START_X`, `pacman_y`=`START_Y`
  - `dir`=3 (left)
  - `moving`=0, `eat_valid`=0, `eat_tile_*`=0
  - `req_valid`=0, `req_dir`=3
  - state IDLE, `frame_clk_q`=0
- Reset mid-sequence aborts the update with no position change.
- Latency:
  - Edge E0 samples the rising edge of `frame_clk`.
  - TURN during E0–E1, FWD during E1–E2, MOVE during E2–E3.
  - New `pacman_x`/`pacman_y` is registered at E3.
  - `eat_valid` is high for the cycle E3–E4 only.
- Keycode arriving on the same cycle as TURN: the register update wins next cycle; TURN uses the previous `req_dir`.
- Position changes by at most one pixel per frame. It is stable for the whole visible frame because the update completes in vertical blank.

## Structure

- `pacman_pkg`:
  - `dir_t` enum (UP=0, RIGHT=1, DOWN=2, LEFT=3)
  - `TILE_SIZE`=16, `GRID_W`=40, `GRID_H`=30, `X_WRAP_MAX`=624
  - keycode constants `KEY_W`, `KEY_A`, `KEY_S`, `KEY_D`
- Sub-module `tile_neighbor`: combinational. Takes the current tile and a `dir_t`; returns the neighbour tile with x wrap plus an `off_grid` flag. It is used by both TURN and FWD.

## Test plan

- Reset, no key, 3 frames: Pac-Man starts at (304,368) heading left with the left neighbour open → `pacman_x` goes 303, 302, 301; `eat_valid` never pulses.
- From (304,368), 16 frames left with no walls → x=288 after frame 16; `eat_valid` pulses once with tile (18,23).
- Aligned at (304,368), `keycode`=0x1A, wall at tile (19,22) → turn rejected, `dir` stays 3, `req_valid` clears. Repeat with tile (19,22) open → `dir`=0, `pacman_y`=367.
- At x=300 heading left, press D → immediate reversal without query; x=301 next frame.
- At x=0 heading left with tile (39,y) open → x=624 after one frame. At x=624 heading right with tile (0,y) open → x=0.
- Assert `Reset` in the cycle after the frame edge at (303,368) → position (304,368) and `dir`=3 next cycle; no `eat_valid`.
